// File: rtl/rle_capture_ctrl.sv
// Capture sequencer for the RLE acquisition path: arms on start, waits for trigger, forwards
// encoded or raw words to sample memory, flushes the encoder on abort and stops at a word limit.
module rle_capture_ctrl #(
   parameter int unsigned CNT_W      = 25,
   parameter int unsigned FLUSH_WAIT = 2
) (
   input  logic             core_clk,
   input  logic             core_rst_n,
   input  logic             cfg_start,
   input  logic             cfg_abort,
   input  logic             cfg_rle_en,
   input  logic [CNT_W-1:0] cfg_limit,
   input  logic             trig_hit,
   input  logic [15:0]      capture_data,
   input  logic [15:0]      enc_data,
   input  logic             enc_valid,
   output logic             enc_run,
   output logic             enc_flush,
   output logic [15:0]      wr_data,
   output logic             wr_valid,
   input  logic             wr_ready,
   output logic [CNT_W-1:0] wr_count,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

   localparam int unsigned FW_W = (FLUSH_WAIT > 1) ? $clog2(FLUSH_WAIT) : 1;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StArmed = 3'd1,
      StRun   = 3'd2,
      StFlush = 3'd3,
      StDone  = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic             rle_en_q, rle_en_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [FW_W-1:0]  fcnt_q, fcnt_d;
   logic [15:0]      wr_data_q, wr_data_d;
   logic             wr_valid_q, wr_valid_d;
   logic             overrun_q, overrun_d;
   logic             enc_run_q, enc_run_d;
   logic             enc_flush_q, enc_flush_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             src_valid;
   logic [15:0]      src_data;
   logic             at_limit;

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state_q     <= StIdle;
         rle_en_q    <= 1'b0;
         limit_q     <= '0;
         cnt_q       <= '0;
         fcnt_q      <= '0;
         wr_data_q   <= '0;
         wr_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         enc_run_q   <= 1'b0;
         enc_flush_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rle_en_q    <= rle_en_d;
         limit_q     <= limit_d;
         cnt_q       <= cnt_d;
         fcnt_q      <= fcnt_d;
         wr_data_q   <= wr_data_d;
         wr_valid_q  <= wr_valid_d;
         overrun_q   <= overrun_d;
         enc_run_q   <= enc_run_d;
         enc_flush_q <= enc_flush_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign src_valid = rle_en_q ? enc_valid : 1'b1;
   assign src_data  = rle_en_q ? enc_data : capture_data;
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign at_limit  = (cnt_inc == limit_q);

   always_comb begin
      state_d    = state_q;
      rle_en_d   = rle_en_q;
      limit_d    = limit_q;
      cnt_d      = cnt_q;
      fcnt_d     = fcnt_q;
      wr_data_d  = wr_data_q;
      wr_valid_d = 1'b0;
      // The encoder cannot be stalled, so a refused word is only flagged, never held.
      overrun_d  = overrun_q | (wr_valid_q & ~wr_ready);
      case (state_q)
         StIdle, StDone: begin
            if (cfg_start) begin
               rle_en_d  = cfg_rle_en;
               limit_d   = cfg_limit;
               cnt_d     = '0;
               overrun_d = 1'b0;
               state_d   = (cfg_limit == '0) ? StDone : StArmed;
            end
         end
         StArmed: begin
            if (cfg_abort) begin
               state_d = StIdle;
            end else if (trig_hit) begin
               state_d = StRun;
            end
         end
         StRun: begin
            fcnt_d = '0;
            if (src_valid) begin
               wr_valid_d = 1'b1;
               wr_data_d  = src_data;
               cnt_d      = cnt_inc;
            end
            if (src_valid && at_limit) begin
               state_d = StDone;
            end else if (cfg_abort) begin
               state_d = rle_en_q ? StFlush : StDone;
            end
         end
         StFlush: begin
            fcnt_d = fcnt_q + FW_W'(1);
            if (enc_valid && (cnt_q < limit_q)) begin
               wr_valid_d = 1'b1;
               wr_data_d  = enc_data;
               cnt_d      = cnt_inc;
               state_d    = StDone;
            end else if (fcnt_q == FW_W'(FLUSH_WAIT - 1)) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      enc_run_d   = (state_d == StRun) || (state_d == StFlush);
      enc_flush_d = (state_q == StRun) && (state_d == StFlush);
      busy_d      = (state_d == StArmed) || (state_d == StRun) || (state_d == StFlush);
      done_d      = (state_d == StDone);
   end

   assign enc_run   = enc_run_q;
   assign enc_flush = enc_flush_q;
   assign wr_data   = wr_data_q;
   assign wr_valid  = wr_valid_q;
   assign wr_count  = cnt_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_rle_capture_ctrl.sv
// Directed bench for rle_capture_ctrl: raw/RLE capture, limit, abort/flush, overrun and
// asynchronous reset, with hand-computed expectations.
module tb_rle_capture_ctrl;

   localparam int unsigned CNT_W = 25;

   logic             core_clk;
   logic             core_rst_n;
   logic             cfg_start, cfg_abort, cfg_rle_en;
   logic [CNT_W-1:0] cfg_limit;
   logic             trig_hit;
   logic [15:0]      capture_data, enc_data;
   logic             enc_valid;
   logic             enc_run, enc_flush;
   logic [15:0]      wr_data;
   logic             wr_valid, wr_ready;
   logic [CNT_W-1:0] wr_count;
   logic             busy, done, overrun;

   rle_capture_ctrl #(.CNT_W(CNT_W), .FLUSH_WAIT(2)) dut (
      .core_clk     (core_clk),
      .core_rst_n   (core_rst_n),
      .cfg_start    (cfg_start),
      .cfg_abort    (cfg_abort),
      .cfg_rle_en   (cfg_rle_en),
      .cfg_limit    (cfg_limit),
      .trig_hit     (trig_hit),
      .capture_data (capture_data),
      .enc_data     (enc_data),
      .enc_valid    (enc_valid),
      .enc_run      (enc_run),
      .enc_flush    (enc_flush),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_count     (wr_count),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun)
   );

   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] cyc;         // index of the upcoming clock edge; raw samples carry it
   logic [15:0] got[$];
   int          nvalid, nflush, saw_busy, saw_run, run_after_done;
   logic [15:0] t_trig;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic clr();
      got.delete();
      nvalid = 0; nflush = 0; saw_busy = 0; saw_run = 0; run_after_done = 0;
   endtask

   // Advance one edge and sample outputs 1 time unit after it.
   task automatic tick();
      @(posedge core_clk);
      #1;
      cyc++;
      capture_data = cyc;
      if (wr_valid) begin
         got.push_back(wr_data);
         nvalid++;
      end
      if (enc_flush) nflush++;
      if (busy) saw_busy++;
      if (enc_run) saw_run++;
      if (enc_run && done) run_after_done++;
   endtask

   task automatic start(input logic rle, input logic [CNT_W-1:0] lim);
      cfg_start = 1'b1; cfg_rle_en = rle; cfg_limit = lim;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic trigger();
      trig_hit = 1'b1;
      t_trig = cyc;
      tick();
      trig_hit = 1'b0;
   endtask

   task automatic send(input logic [15:0] w);
      enc_valid = 1'b1; enc_data = w;
      tick();
      enc_valid = 1'b0;
      tick();
   endtask

   task automatic wait_valid(input int n);
      for (int i = 0; i < 30 && nvalid < n; i++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      core_rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_rle_en = 1'b0;
      cfg_limit = '0; trig_hit = 1'b0; capture_data = '0; enc_data = '0; enc_valid = 1'b0;
      wr_ready = 1'b1; cyc = '0;
      clr();
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_run", enc_run, 0);
      check("rst_valid", wr_valid, 0);
      check("rst_count", wr_count, 0);
      core_rst_n = 1'b1;
      tick();

      // Raw mode, limit 5: five consecutive capture samples after the trigger.
      cyc = 16'd0; capture_data = cyc;
      clr();
      start(1'b0, 25'd5);
      check("t1_busy", busy, 1);
      while (cyc < 16'd10) tick();
      trigger();
      check("t1_run", enc_run, 1);
      check("t1_novalid", wr_valid, 0);
      wait_valid(5);
      check("t1_done", done, 1);
      check("t1_busy_end", busy, 0);
      check("t1_run_end", enc_run, 0);
      check("t1_count", wr_count, 5);
      repeat (3) tick();
      check("t1_nvalid", nvalid, 5);
      check("t1_run_after_done", run_after_done, 0);
      for (int i = 0; i < 5; i++)
         if (i < got.size()) check("t1_word", got[i], 32'(t_trig) + 32'(i) + 1);

      // RLE mode, limit 3: fourth encoder word is dropped.
      clr();
      start(1'b1, 25'd3);
      trigger();
      send(16'hA0A0);
      send(16'hB1B1);
      enc_valid = 1'b1; enc_data = 16'hC2C2;
      tick();
      enc_valid = 1'b0;
      check("t2_done_with_c", done, 1);
      check("t2_valid_c", wr_valid, 1);
      send(16'hD3D3);
      check("t2_nvalid", nvalid, 3);
      check("t2_count", wr_count, 3);
      if (got.size() == 3) begin
         check("t2_w0", got[0], 16'hA0A0);
         check("t2_w1", got[1], 16'hB1B1);
         check("t2_w2", got[2], 16'hC2C2);
      end

      // RLE abort after two words; encoder answers the flush one cycle later.
      clr();
      start(1'b1, 25'd100);
      trigger();
      send(16'h1111);
      send(16'h2222);
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      check("t3_flush", enc_flush, 1);
      check("t3_flush_run", enc_run, 1);
      check("t3_flush_done", done, 0);
      tick();
      check("t3_flush_once", enc_flush, 0);
      enc_valid = 1'b1; enc_data = 16'hF00F;
      tick();
      enc_valid = 1'b0;
      check("t3_done", done, 1);
      check("t3_valid_f", wr_valid, 1);
      check("t3_word_f", wr_data, 16'hF00F);
      check("t3_count", wr_count, 3);
      repeat (2) tick();
      check("t3_nflush", nflush, 1);
      check("t3_nvalid", nvalid, 3);

      // Zero limit completes immediately without ever being busy.
      clr();
      start(1'b0, 25'd0);
      check("t4_done", done, 1);
      repeat (3) tick();
      check("t4_nvalid", nvalid, 0);
      check("t4_busy_seen", saw_busy, 0);

      // Abort beats a simultaneous trigger in ARMED.
      start(1'b0, 25'd4);
      check("t4_armed", busy, 1);
      clr();
      cfg_abort = 1'b1; trig_hit = 1'b1;
      tick();
      cfg_abort = 1'b0; trig_hit = 1'b0;
      check("t4_idle_busy", busy, 0);
      check("t4_idle_done", done, 0);
      repeat (3) tick();
      check("t4_run_seen", saw_run, 0);

      // Refused words set a sticky overrun that only a new start clears.
      clr();
      start(1'b1, 25'd2);
      trigger();
      wr_ready = 1'b0;
      send(16'h5A5A);
      send(16'hA5A5);
      check("t5_done", done, 1);
      check("t5_overrun", overrun, 1);
      check("t5_count", wr_count, 2);
      repeat (3) tick();
      check("t5_sticky", overrun, 1);
      wr_ready = 1'b1;
      start(1'b0, 25'd5);
      check("t5_clear", overrun, 0);
      check("t5_restart", busy, 1);

      // Asynchronous reset in the middle of a raw run.
      start(1'b0, 25'd50);
      trigger();
      repeat (3) tick();
      check("t6_running", enc_run, 1);
      #2 core_rst_n = 1'b0;
      #1;
      check("t6_rst_run", enc_run, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_count", wr_count, 0);
      check("t6_rst_valid", wr_valid, 0);
      check("t6_rst_data", wr_data, 0);
      tick();
      core_rst_n = 1'b1;
      clr();
      cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
      trig_hit = 1'b1; tick(); trig_hit = 1'b0;
      tick();
      check("t6_ignored_busy", saw_busy, 0);
      check("t6_ignored_run", saw_run, 0);
      start(1'b0, 25'd3);
      trigger();
      wait_valid(3);
      check("t6_done", done, 1);
      check("t6_count", wr_count, 3);
      for (int i = 0; i < 3; i++)
         if (i < got.size()) check("t6_word", got[i], 32'(t_trig) + 32'(i) + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
